// File: rtl/fwd_hazard_pkg.sv
// fwd_hazard_pkg: opcode classes, select encoding and tracker entry type shared by fwd_hazard_unit
package fwd_hazard_pkg;
   typedef enum logic [1:0] {CLS_ALU = 2'b00, CLS_IMM = 2'b01, CLS_MEM = 2'b10, CLS_NOP = 2'b11} cls_t;
   localparam int SEL_RF = 0;
   // Tracker dst is sized for the widest supported register file; narrower addresses are zero-extended.
   localparam int MAX_REG_W = 8;
   typedef struct packed {
      logic                 valid;
      logic [MAX_REG_W-1:0] dst;
      logic                 is_load;
   } trk_entry_t;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: youngest-wins priority compare of one source register against the producer tracker
module fwd_match
   import fwd_hazard_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int DEPTH = 3,
   parameter int SEL_W = $clog2(DEPTH + 1)
) (
   input  logic [REG_W-1:0]       src,
   input  logic                   used,
   input  trk_entry_t [DEPTH:1]   trk,
   output logic                   hit,
   output logic [SEL_W-1:0]       sel
);
   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      sel = SEL_W'(SEL_RF);
      for (int k = DEPTH; k >= 1; k--)
         if (used && src != '0 && trk[k].valid && trk[k].dst == MAX_REG_W'(src)) sel = SEL_W'(k);
   end
   assign hit = sel != SEL_W'(SEL_RF);
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: decode stage with producer tracking, forwarding selects and load-use stall
module fwd_hazard_unit
   import fwd_hazard_pkg::*;
#(
   parameter int OP_W  = 5,
   parameter int REG_W = 5,
   parameter int IMM_W = 8,
   parameter int DEPTH = 3,
   parameter int SEL_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [OP_W+3*REG_W-1:0] ins,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic                    out_valid,
   output logic [OP_W-1:0]         op_dec,
   output logic [REG_W-1:0]        RW_dec,
   output logic [IMM_W-1:0]        Imm,
   output logic                    imm_sel,
   output logic                    mem_en_dec,
   output logic                    mem_rw_dec,
   output logic                    mem_mux_sel_dec,
   output logic [SEL_W-1:0]        mux_sel_a,
   output logic [SEL_W-1:0]        mux_sel_b,
   output logic [SEL_W-1:0]        mux_sel_st,
   output logic                    stall
);
   logic [OP_W-1:0]      op;
   logic [REG_W-1:0]     rw, ra, rb;
   cls_t                 cls;
   logic                 use_a, use_b, use_st, is_ld, wr, hazard, issue;
   logic                 hit_a, hit_b, hit_st;
   logic [SEL_W-1:0]     sel_a, sel_b, sel_st;
   trk_entry_t [DEPTH:1] trk;
   assign {op, rw, ra, rb} = ins;
   assign cls    = cls_t'(op[OP_W-1 -: 2]);
   assign use_a  = cls != CLS_NOP;
   assign use_b  = cls == CLS_ALU;
   assign use_st = cls == CLS_MEM && op[0];
   assign is_ld  = cls == CLS_MEM && !op[0];
   assign wr     = cls == CLS_ALU || cls == CLS_IMM || is_ld;
   fwd_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a
      (.src(ra), .used(use_a), .trk(trk), .hit(hit_a), .sel(sel_a));
   fwd_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b
      (.src(rb), .used(use_b), .trk(trk), .hit(hit_b), .sel(sel_b));
   fwd_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_st
      (.src(rw), .used(use_st), .trk(trk), .hit(hit_st), .sel(sel_st));
   // A load one edge ahead has no data yet; any consumer of it must wait one bubble.
   assign hazard = in_valid && trk[1].is_load &&
                   ((hit_a && sel_a == SEL_W'(1)) || (hit_b && sel_b == SEL_W'(1)) ||
                    (hit_st && sel_st == SEL_W'(1)));
   assign in_ready = !hazard;
   assign issue    = in_valid && !hazard && !flush;
   always_ff @(posedge clk)
      if (reset || flush) trk <= '0;
      else begin
         for (int k = DEPTH; k > 1; k--) trk[k] <= trk[k-1];
         trk[1] <= issue ? trk_entry_t'{valid: wr, dst: MAX_REG_W'(rw), is_load: is_ld} : '0;
      end
   always_ff @(posedge clk) begin
      out_valid <= !reset && issue;
      stall     <= !reset && !flush && hazard;
      if (reset || !issue) begin
         op_dec          <= '0;
         RW_dec          <= '0;
         Imm             <= '0;
         imm_sel         <= 1'b0;
         mem_en_dec      <= 1'b0;
         mem_rw_dec      <= 1'b0;
         mem_mux_sel_dec <= 1'b0;
         mux_sel_a       <= '0;
         mux_sel_b       <= '0;
         mux_sel_st      <= '0;
      end else begin
         op_dec          <= op;
         RW_dec          <= rw;
         Imm             <= ins[IMM_W-1:0];
         imm_sel         <= cls == CLS_IMM || cls == CLS_MEM;
         mem_en_dec      <= cls == CLS_MEM;
         mem_rw_dec      <= use_st;
         mem_mux_sel_dec <= is_ld;
         mux_sel_a       <= sel_a;
         mux_sel_b       <= sel_b;
         mux_sel_st      <= sel_st;
      end
   end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the decode-stage data-dependency block of the pipelined core.
- Decodes an [op | rw | ra | rb] instruction word and registers the control and immediate fields.
- Tracks the destinations of up to DEPTH in-flight producers and generates forwarding selects for operand A, operand B and store data.
- Adds behaviour the previous generation lacks: valid/ready handshake, load-use stall with bubble insertion, pipeline flush, and register-0 exclusion.

Parameters:
- OP_W, 5, opcode field width
- REG_W, 5, register address width
- IMM_W, 8, immediate width, taken from ins[IMM_W-1:0]
- DEPTH, 3, tracked producer stages (1 = EX, 2 = MEM, 3 = WB, ...)
- SEL_W, $clog2(DEPTH+1), forwarding select width (2 at default)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ins  in  OP_W+3*REG_W  instruction word {op, rw, ra, rb}
- in_valid  in  1  ins is valid this cycle
- in_ready  out  1  ins is consumed at this edge (combinational)
- flush  in  1  discard tracked producers (branch redirect)
- out_valid  out  1  decoded outputs describe a real instruction
- op_dec  out  OP_W  registered opcode
- RW_dec  out  REG_W  registered destination / store-data register
- Imm  out  IMM_W  registered immediate
- imm_sel  out  1  operand B takes Imm
- mem_en_dec  out  1  memory access
- mem_rw_dec  out  1  1 = store, 0 = load
- mem_mux_sel_dec  out  1  writeback selects memory data
- mux_sel_a  out  SEL_W  operand A source: 0 = register file, k = stage k
- mux_sel_b  out  SEL_W  operand B source, same encoding
- mux_sel_st  out  SEL_W  store-data source, same encoding
- stall  out  1  load-use bubble issued this cycle (registered)

Behaviour:
- Opcode class is op[OP_W-1:OP_W-2]:
  - 00: ALU reg-reg; reads ra and rb; writes rw.
  - 01: ALU immediate; reads ra; imm_sel=1; writes rw.
  - 10: memory. op[0]=0 is a load (reads ra, writes rw, mem_mux_sel=1). op[0]=1 is a store (reads ra and rw; no write; mem_rw=1). imm_sel=1 for both.
  - 11: NOP (no reads, no write).
- Tracker: DEPTH entries {valid, dst, is_load}. Entry k is the instruction issued k edges ago. The tracker shifts at every edge, and entry 1 takes the issued instruction or a bubble (valid=0).
- Dependency match: a source register equals entry k's dst, entry k is valid, and the register is nonzero. Register 0 never matches. The youngest match wins (smallest k), and select = k. With no match, select = 0. A select is forced to 0 when its source is unused (e.g. mux_sel_b when imm_sel=1).
- Load-use hazard (combinational): in_valid, a used source matches entry 1, and entry 1 is_load.
- in_ready = !hazard. It equals 1 after reset.
- Issue: in_valid && in_ready at an edge registers all decoded outputs and sets out_valid=1, stall=0. Latency is 1 cycle.
- Stall: when the hazard is present, the edge issues a bubble: out_valid=0, all control outputs 0, stall=1, tracker shifts in a bubble. The upstream must hold ins. At the next edge the load sits in entry 2, so the consumer issues with select 2. A stall never exceeds 1 cycle.
- in_valid=0: bubble issued, stall=0.
- flush: at the edge, all tracker valid bits are cleared, a bubble is issued and stall=0. in_valid is ignored that cycle, so nothing is consumed and in_ready has no effect. flush takes priority over a simultaneous hazard.
- reset: every registered output goes to 0 (out_valid, stall, selects, control, Imm, op_dec, RW_dec) and the tracker is cleared. Reset takes priority over flush. Reset asserted mid-stall discards the pending consumer state; the upstream re-presents ins.
- Producers older than DEPTH are not tracked; the register file supplies their values.

Decomposition:
- Package fwd_hazard_pkg holds: class encodings (CLS_ALU, CLS_IMM, CLS_MEM, CLS_NOP), the select encoding constant SEL_RF=0, and the tracker-entry struct {valid, dst, is_load}.
- Sub-module fwd_match: one instance per source. Parametrised priority comparator over the tracker, producing hit and select.

Test Plan:
- Reset, then ins = 00000_00001_00010_00011 with an empty tracker -> next edge: out_valid=1, op_dec=0, RW_dec=1, mux_sel_a=0, mux_sel_b=0.
- Two back-to-back ALU instructions: 00000_00100_00001_00010, then 00000_00101_00100_00100 -> second issues with mux_sel_a=1, mux_sel_b=1.
- Load 10000_00100_00001_xxxxx, then 00000_00110_00100_00000 -> in_ready=0 for one cycle and a bubble with stall=1; the consumer then issues with mux_sel_a=2.
- Dependency on r0: 00000_00000_..., then an instruction reading ra=0 -> mux_sel_a=0. Dependency at distance 3 -> select 3; distance 4 -> select 0.
- Store 10001_00111_00010_00101 after a write to r7 at distance 2 -> mux_sel_st=2, mux_sel_b=0, imm_sel=1, Imm=0x45, mem_en=1, mem_rw=1.
- flush asserted while a load is in entry 1 with a dependent ins present -> the next consumer issues with selects 0 and no stall. Reset asserted during a stall -> all outputs 0 at the next edge.
